param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_pkg.sv | 15 +
 rtl/param_fifo_ram.sv | 29 ++
 rtl/param_fifo.sv | 105 ++++++++++
 tb/tb_param_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: default configuration constants and the count-width helper
// shared by the FIFO top and its storage.
package param_fifo_pkg;

    localparam int DEF_W_DATA = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_AF_THR = 12;
    localparam int DEF_AE_THR = 4;

    // Occupancy spans 0..DEPTH inclusive, so one bit more than the pointer width.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// param_fifo_ram: DEPTH x W_DATA storage, synchronous write, asynchronous read.
// Ports:
//   clk     - clock, write on rising edge
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data, combinational from i_raddr
module param_fifo_ram #(
    parameter int W_DATA = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W_DATA-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W_DATA-1:0]        o_rdata
);

    logic [W_DATA-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with occupancy flags and error pulses.
// Ports:
//   clk                        - clock, all state changes on rising edge
//   rst                        - asynchronous active-low reset
//   push / data                - write request and write data
//   pop / rd_data              - read request and read data
//   full, empty                - count == DEPTH, count == 0
//   almost_full, almost_empty  - count >= AF_THR, count <= AE_THR
//   count                      - registered occupancy
//   overflow, underflow        - one-cycle pulses after a dropped push / ignored pop
// Build option: define PARAM_FIFO_FWFT_EN for first-word-fall-through reads
// (rd_data shows the head entry); otherwise rd_data is registered on each pop.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int W_DATA = DEF_W_DATA,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_THR = DEF_AF_THR,
    parameter int AE_THR = DEF_AE_THR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W_DATA-1:0]          data,
    output logic [W_DATA-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF   = CW'(AF_THR);
    localparam logic [CW-1:0] C_AE   = CW'(AE_THR);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic [W_DATA-1:0] w_head;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign empty        = r_count == '0;
    assign full         = r_count == C_FULL;
    assign almost_full  = r_count >= C_AF;
    assign almost_empty = r_count <= C_AE;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    param_fifo_ram #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // DEPTH is a power of two, so natural pointer rollover is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count     <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            r_overflow  <= push & ~w_push_ok;
            r_underflow <= pop & empty;
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    assign rd_data = w_head;
`else
    logic [W_DATA-1:0] r_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_data <= '0;
        else if (w_pop_ok) r_rd_data <= w_head;
    end

    assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the FIFO.
module tb_param_fifo;
    import param_fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;
    localparam int CW = cnt_w(D);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  data = '0;
    logic [W-1:0]  rd_data;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    param_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .data         (data),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] last_rd = '0;
    bit           exp_ovf = 0;
    bit           exp_udf = 0;

    typedef struct {
        bit           p;
        bit           o;
        logic [W-1:0] d;
        int           cnt;
        bit           f;
        bit           e;
        bit           af;
        bit           ae;
        bit           ov;
        bit           ud;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_rd = '0;
        exp_ovf = 0;
        exp_udf = 0;
    endtask

    task automatic check_state();
        chk("count", count, q.size());
        chk("full", full, q.size() == D);
        chk("empty", empty, q.size() == 0);
        chk("almost_full", almost_full, q.size() >= AF);
        chk("almost_empty", almost_empty, q.size() <= AE);
        chk("overflow", overflow, exp_ovf);
        chk("underflow", underflow, exp_udf);
`ifdef PARAM_FIFO_FWFT_EN
        if (q.size() > 0) chk("rd_head", rd_data, q[0]);
`else
        chk("rd_data", rd_data, last_rd);
`endif
    endtask

    // Called at a falling edge; drives one cycle and checks at the next falling edge.
    task automatic step(input bit p, input bit o, input logic [W-1:0] d);
        bit pop_ok, push_ok;
        push = p;
        pop = o;
        data = d;
        pop_ok = o && q.size() > 0;
        push_ok = p && (q.size() < D || pop_ok);
        exp_ovf = p && !push_ok;
        exp_udf = o && q.size() == 0;
        @(posedge clk);
        if (pop_ok) last_rd = q.pop_front();
        if (push_ok) q.push_back(d);
        @(negedge clk);
        push = 0;
        pop = 0;
        check_state();
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            tv.push_back('{1, 0, W'(i + 1), i + 1, i == 15, 0, i + 1 >= 12, i + 1 <= 4, 0, 0});
        tv.push_back('{1, 0, 8'hAA, 16, 1, 0, 1, 0, 1, 0});
        tv.push_back('{0, 0, 8'h00, 16, 1, 0, 1, 0, 0, 0});
        tv.push_back('{1, 1, 8'h77, 16, 1, 0, 1, 0, 0, 0});

        @(negedge clk);
        model_reset();
        check_state();
        rst = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            step(tv[i].p, tv[i].o, tv[i].d);
            chk("tv_count", count, tv[i].cnt);
            chk("tv_full", full, tv[i].f);
            chk("tv_empty", empty, tv[i].e);
            chk("tv_af", almost_full, tv[i].af);
            chk("tv_ae", almost_empty, tv[i].ae);
            chk("tv_ovf", overflow, tv[i].ov);
            chk("tv_udf", underflow, tv[i].ud);
        end
`ifndef PARAM_FIFO_FWFT_EN
        chk("popped_first", rd_data, 8'h01);
`endif
        for (int i = 0; i < 15; i++) step(0, 1, '0);
`ifdef PARAM_FIFO_FWFT_EN
        chk("last_word", rd_data, 8'h77);
`endif
        step(0, 1, '0);
`ifndef PARAM_FIFO_FWFT_EN
        chk("last_word", rd_data, 8'h77);
`endif
        chk("drained", empty, 1'b1);

        step(0, 1, '0);
        chk("udf_pulse", underflow, 1'b1);
        step(0, 0, '0);
        chk("udf_clear", underflow, 1'b0);
        step(1, 1, 8'h55);
        chk("push_on_empty_pop", count, 1);
        step(0, 1, '0);

        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 40) % 2 == 0) ? 75 : 25;
            step($urandom_range(99) < bias, $urandom_range(99) < 100 - bias, W'($urandom));
        end

        // Asynchronous reset mid-burst with nine entries held.
        while (q.size() > 0) step(0, 1, '0);
        for (int i = 0; i < 9; i++) step(1, 0, W'(8'h30 + i));
        chk("pre_reset_count", count, 9);
        push = 1'b1;
        data = 8'hEE;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_state();
        push = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_state();

        step(1, 0, 8'h01);
`ifdef PARAM_FIFO_FWFT_EN
        chk("fwft_first", rd_data, 8'h01);
`endif
        for (int i = 1; i < 16; i++) step(1, 0, W'(i + 1));
        chk("refill_full", full, 1'b1);
        chk("refill_count", count, 16);
        while (q.size() > 0) step(0, 1, '0);
        step(0, 1, '0);
        chk("re_udf", underflow, 1'b1);
        step(1, 1, 8'h55);
        chk("re_push_pop", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
